// File: rtl/skid_buffer_async_pkg.sv
// ---------------------------------------------------------------
// skid_buffer_async_pkg : state encoding and widths for the skid buffer
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package skid_buffer_async_pkg;

  localparam int SKB_STATE_W = 2;
  localparam int SKB_OCC_W   = 2;

  // Encoding doubles as the held-word count, so occupancy is the state itself.
  localparam logic [SKB_STATE_W-1:0] SKB_EMPTY = 2'd0;
  localparam logic [SKB_STATE_W-1:0] SKB_BUSY  = 2'd1;
  localparam logic [SKB_STATE_W-1:0] SKB_FULL  = 2'd2;

endpackage : skid_buffer_async_pkg

`default_nettype wire

// File: rtl/skid_buffer_async.sv
// ---------------------------------------------------------------
// skid_buffer_async : valid/ready stage with main + skid slot, registered s_ready
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module skid_buffer_async
  import skid_buffer_async_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [SKB_OCC_W-1:0] occupancy
);

  logic [SKB_STATE_W-1:0] r_state;
  logic [SKB_STATE_W-1:0] w_state_next;
  logic                   r_s_ready;
  logic [WIDTH-1:0]       r_main;
  logic [WIDTH-1:0]       r_skid;

  logic w_acc;
  logic w_emt;
  logic w_main_load;
  logic w_main_from_skid;
  logic w_skid_load;

  assign w_acc = s_valid && r_s_ready;
  assign w_emt = m_valid && m_ready;

  always_comb begin
    w_state_next     = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    case (r_state)
      SKB_EMPTY: begin
        if (w_acc) begin
          w_state_next = SKB_BUSY;
          w_main_load  = 1'b1;
        end
      end
      SKB_BUSY: begin
        if (w_acc && w_emt) begin
          w_main_load = 1'b1;
        end else if (w_acc) begin
          w_state_next = SKB_FULL;
          w_skid_load  = 1'b1;
        end else if (w_emt) begin
          w_state_next = SKB_EMPTY;
        end
      end
      SKB_FULL: begin
        // s_ready is low here, so only the emit side can move the state
        if (w_emt) begin
          w_state_next     = SKB_BUSY;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = SKB_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= SKB_EMPTY;
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_s_ready <= (w_state_next != SKB_FULL);
    end
  end

  // Data slots carry no reset: m_data is only meaningful while m_valid is high.
  always_ff @(posedge clk) begin
    if (w_main_load) begin
      r_main <= s_data;
    end else if (w_main_from_skid) begin
      r_main <= r_skid;
    end
    if (w_skid_load) begin
      r_skid <= s_data;
    end
  end

  assign s_ready   = r_s_ready;
  assign m_valid   = (r_state != SKB_EMPTY);
  assign m_data    = r_main;
  assign occupancy = r_state;

endmodule : skid_buffer_async

`default_nettype wire

// File: tb/tb_skid_buffer_async.sv
// ---------------------------------------------------------------
// tb_skid_buffer_async : directed + random scoreboard bench for skid_buffer_async
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_skid_buffer_async;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       occupancy;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] sb_q[$];
  logic             exp_ready;

  skid_buffer_async #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference for the registered ready: low in reset, else "model not full" after each edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_ready = 1'b0;
    else        exp_ready = (sb_q.size() != 2);
  end

  // Monitor: state checks first (pre-edge view), then pop emits and push accepts.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_s_ready", {31'd0, s_ready}, 32'd0);
      check("rst_occ", {30'd0, occupancy}, 32'd0);
    end else begin
      check("occupancy", {30'd0, occupancy}, sb_q.size());
      check("m_valid", {31'd0, m_valid}, {31'd0, (sb_q.size() != 0)});
      check("s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_emit", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          check("m_data", {24'd0, m_data}, {24'd0, sb_q.pop_front()});
        end
      end
      if (s_valid && s_ready) sb_q.push_back(s_data);
    end
  end

  // Present d and hold it until the buffer takes it; returns at posedge+1 after acceptance.
  task automatic send(input logic [WIDTH-1:0] d);
    int k;
    k = 0;
    s_valid = 1'b1;
    s_data  = d;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      k++;
      if (k > 50) begin
        check("send_timeout", {24'd0, d}, 32'hFFFF_FFFF);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] rnd_data;
    time t0;

    reset   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    m_ready = 1'b0;

    // Reset held with upstream valid: nothing accepted, outputs idle
    tick(3);
    check("hold_s_ready", {31'd0, s_ready}, 32'd0);
    check("hold_m_valid", {31'd0, m_valid}, 32'd0);
    s_valid = 1'b0;
    reset   = 1'b1;
    tick(1);
    check("release_s_ready", {31'd0, s_ready}, 32'd1);
    check("release_m_valid", {31'd0, m_valid}, 32'd0);

    // Single word, one-cycle latency
    send(8'hA5);
    check("single_m_valid", {31'd0, m_valid}, 32'd1);
    check("single_m_data", {24'd0, m_data}, 32'hA5);
    m_ready = 1'b1;
    tick(2);

    // Streaming at full rate
    t0 = $time;
    for (int i = 1; i <= 16; i++) send(WIDTH'(i));
    check("stream_cycles", ($time - t0) / 10, 32'd16);
    tick(2);

    // Backpressure fill, third word held upstream
    m_ready = 1'b0;
    send(8'h11);
    send(8'h22);
    s_valid = 1'b1;
    s_data  = 8'h33;
    @(negedge clk);
    check("fill_occ", {30'd0, occupancy}, 32'd2);
    check("fill_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    tick(2);
    m_ready = 1'b1;
    send(8'h33);
    tick(4);

    // Simultaneous accept and emit in BUSY
    m_ready = 1'b0;
    send(8'h40);
    m_ready = 1'b1;
    send(8'h41);
    check("passthru_m_data", {24'd0, m_data}, 32'h41);
    check("passthru_occ", {30'd0, occupancy}, 32'd1);
    tick(2);

    // Reset pulse between edges while FULL drops both words
    m_ready = 1'b0;
    send(8'h55);
    send(8'h66);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_occ", {30'd0, occupancy}, 32'd0);
    check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    reset   = 1'b1;
    m_ready = 1'b1;
    tick(4);
    check("post_rst_m_valid", {31'd0, m_valid}, 32'd0);

    // Random valid/ready toggling; the data counter advances only on acceptance
    rnd_data = 8'h80;
    s_valid  = 1'b0;
    s_data   = rnd_data;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (s_valid && s_ready) rnd_data = rnd_data + 8'd1;
      @(posedge clk); #1;
      s_valid = 1'($urandom_range(0, 1));
      s_data  = rnd_data;
      m_ready = 1'($urandom_range(0, 1));
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick(4);
    check("drain_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_skid_buffer_async

`default_nettype wire
